// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW core sequencer and its datapath.
package dtw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    RESULT
  } dtw_ctrl_state_t;

  // Wide enough for any supported WORD_LEN; users slice the low bits.
  localparam logic [63:0] DTW_SCORE_INVALID = '1;
  localparam logic [31:0] DTW_POS_INVALID   = 32'hFFFF_FFFF;

endpackage

// File: rtl/dtw_core_ctrl.sv
// Sequencer for dtw_core_datapath: load squiggle, stream reference, collect result.
// Define DTW_CTRL_TIMEOUT_EN to add a DRAIN watchdog that reports res_timeout.
module dtw_core_ctrl
  import dtw_pkg::*;
#(
  parameter int WORD_LEN     = 16,
  parameter int SQG_LEN      = 250,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         ref_len,
  output logic                busy,
  input  logic                sqg_valid,
  output logic                sqg_ready,
  input  logic [WORD_LEN-1:0] sqg_data,
  input  logic                ref_valid,
  output logic                ref_ready,
  input  logic [WORD_LEN-1:0] ref_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WORD_LEN-1:0] res_score,
  output logic [31:0]         res_position,
  output logic                res_timeout,
  output logic                dp_load_squiggle,
  output logic [WORD_LEN-1:0] dp_squiggle_word,
  output logic                dp_running,
  output logic [WORD_LEN-1:0] dp_reference_word,
  output logic [31:0]         dp_reference_len,
  input  logic [WORD_LEN-1:0] dp_best_score,
  input  logic [31:0]         dp_best_position,
  input  logic                dp_done
);

  localparam logic [31:0]         SQG_LAST      = 32'(SQG_LEN - 1);
  localparam logic [WORD_LEN-1:0] SCORE_INVALID = DTW_SCORE_INVALID[WORD_LEN-1:0];

  if (WORD_LEN < 1 || WORD_LEN > 64 || SQG_LEN < 1 || DONE_TIMEOUT < 1) begin : g_bad_params
    $error("dtw_core_ctrl: illegal parameter values");
  end

  dtw_ctrl_state_t     state_q, state_d;
  logic [31:0]         len_q, len_d;
  logic [31:0]         sqg_cnt_q, sqg_cnt_d;
  logic [31:0]         ref_cnt_q, ref_cnt_d;
  logic                load_q, load_d;
  logic [WORD_LEN-1:0] sqg_word_q, sqg_word_d;
  logic                run_q, run_d;
  logic [WORD_LEN-1:0] ref_word_q, ref_word_d;
  logic [WORD_LEN-1:0] score_q, score_d;
  logic [31:0]         pos_q, pos_d;
`ifdef DTW_CTRL_TIMEOUT_EN
  localparam logic [31:0] WDOG_LAST = 32'(DONE_TIMEOUT - 1);
  logic                tmo_q, tmo_d;
  logic [31:0]         wdog_q, wdog_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      sqg_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      load_q     <= 1'b0;
      sqg_word_q <= '0;
      run_q      <= 1'b0;
      ref_word_q <= '0;
      score_q    <= '0;
      pos_q      <= '0;
`ifdef DTW_CTRL_TIMEOUT_EN
      tmo_q      <= 1'b0;
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sqg_cnt_q  <= sqg_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      load_q     <= load_d;
      sqg_word_q <= sqg_word_d;
      run_q      <= run_d;
      ref_word_q <= ref_word_d;
      score_q    <= score_d;
      pos_q      <= pos_d;
`ifdef DTW_CTRL_TIMEOUT_EN
      tmo_q      <= tmo_d;
      wdog_q     <= wdog_d;
`endif
    end
  end

  // Strobes default low each cycle; data words hold across bubbles.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sqg_cnt_d  = sqg_cnt_q;
    ref_cnt_d  = ref_cnt_q;
    load_d     = 1'b0;
    sqg_word_d = sqg_word_q;
    run_d      = 1'b0;
    ref_word_d = ref_word_q;
    score_d    = score_q;
    pos_d      = pos_q;
`ifdef DTW_CTRL_TIMEOUT_EN
    tmo_d      = tmo_q;
    wdog_d     = wdog_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = ref_len;
          sqg_cnt_d = '0;
          ref_cnt_d = '0;
`ifdef DTW_CTRL_TIMEOUT_EN
          tmo_d     = 1'b0;
`endif
          if (ref_len != 32'd0) begin
            state_d = LOAD;
          end else begin
            score_d = SCORE_INVALID;
            pos_d   = DTW_POS_INVALID;
            state_d = RESULT;
          end
        end
      end

      LOAD: begin
        if (sqg_valid) begin
          load_d     = 1'b1;
          sqg_word_d = sqg_data;
          sqg_cnt_d  = sqg_cnt_q + 32'd1;
          if (sqg_cnt_q == SQG_LAST) state_d = STREAM;
        end
      end

      STREAM: begin
        if (ref_valid) begin
          run_d      = 1'b1;
          ref_word_d = ref_data;
          ref_cnt_d  = ref_cnt_q + 32'd1;
          if (ref_cnt_q == len_q - 32'd1) begin
            state_d = DRAIN;
`ifdef DTW_CTRL_TIMEOUT_EN
            wdog_d  = '0;
`endif
          end
        end
      end

      // A done in the same cycle as the watchdog expiry still yields a real result.
      DRAIN: begin
        if (dp_done) begin
          score_d = dp_best_score;
          pos_d   = dp_best_position;
          state_d = RESULT;
`ifdef DTW_CTRL_TIMEOUT_EN
          tmo_d   = 1'b0;
        end else if (wdog_q == WDOG_LAST) begin
          score_d = SCORE_INVALID;
          pos_d   = DTW_POS_INVALID;
          tmo_d   = 1'b1;
          state_d = RESULT;
        end else begin
          wdog_d  = wdog_q + 32'd1;
`endif
        end
      end

      RESULT: begin
        if (res_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy              = (state_q != IDLE);
  assign sqg_ready         = (state_q == LOAD);
  assign ref_ready         = (state_q == STREAM);
  assign res_valid         = (state_q == RESULT);
  assign res_score         = score_q;
  assign res_position      = pos_q;
  assign dp_load_squiggle  = load_q;
  assign dp_squiggle_word  = sqg_word_q;
  assign dp_running        = run_q;
  assign dp_reference_word = ref_word_q;
  assign dp_reference_len  = len_q;
`ifdef DTW_CTRL_TIMEOUT_EN
  assign res_timeout       = tmo_q;
`else
  assign res_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Scoreboard bench for dtw_core_ctrl with SQG_LEN=5 and a fabricated datapath.
// Define DTW_CTRL_TIMEOUT_EN to also exercise the DRAIN watchdog (DONE_TIMEOUT=16).
module tb_dtw_core_ctrl;
  import dtw_pkg::*;

  localparam int WL  = 16;
  localparam int SL  = 5;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   refLen = '0;
  logic          busy;
  logic          sqgValid = 1'b0;
  logic          sqgReady;
  logic [WL-1:0] sqgData = '0;
  logic          refValid = 1'b0;
  logic          refReady;
  logic [WL-1:0] refData = '0;
  logic          resValid;
  logic          resReady = 1'b0;
  logic [WL-1:0] resScore;
  logic [31:0]   resPosition;
  logic          resTimeout;
  logic          dpLoad;
  logic [WL-1:0] dpSqgWord;
  logic          dpRunning;
  logic [WL-1:0] dpRefWord;
  logic [31:0]   dpRefLen;
  logic [WL-1:0] dpBestScore = '0;
  logic [31:0]   dpBestPos = '0;
  logic          dpDone = 1'b0;

  typedef struct {
    logic [WL-1:0] score;
    logic [31:0]   pos;
    logic          tmo;
  } resExp_t;

  logic [WL-1:0] expSqg[$];
  logic [WL-1:0] expRef[$];
  resExp_t       expRes[$];
  resExp_t       popped;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int loadCnt = 0, firstLoad = 0, lastLoad = 0;
  int runCnt = 0, firstRun = 0, lastRun = 0;

  dtw_core_ctrl #(.WORD_LEN(WL), .SQG_LEN(SL), .DONE_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_len(refLen), .busy(busy),
    .sqg_valid(sqgValid), .sqg_ready(sqgReady), .sqg_data(sqgData),
    .ref_valid(refValid), .ref_ready(refReady), .ref_data(refData),
    .res_valid(resValid), .res_ready(resReady), .res_score(resScore),
    .res_position(resPosition), .res_timeout(resTimeout),
    .dp_load_squiggle(dpLoad), .dp_squiggle_word(dpSqgWord),
    .dp_running(dpRunning), .dp_reference_word(dpRefWord),
    .dp_reference_len(dpRefLen), .dp_best_score(dpBestScore),
    .dp_best_position(dpBestPos), .dp_done(dpDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL globalTimeout: observed no end of test, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every datapath strobe and every result handshake pops the oldest expectation.
  always @(negedge clk) begin
    checkOutput("readyExclusive", 64'(sqgReady & refReady), 64'd0);
    if (dpLoad) begin
      if (expSqg.size() == 0) checkOutput("sqgUnexpected", 64'd1, 64'd0);
      else checkOutput("sqgWord", 64'(dpSqgWord), 64'(expSqg.pop_front()));
      if (loadCnt == 0) firstLoad = cyc;
      lastLoad = cyc;
      loadCnt++;
    end
    if (dpRunning) begin
      if (expRef.size() == 0) checkOutput("refUnexpected", 64'd1, 64'd0);
      else checkOutput("refWord", 64'(dpRefWord), 64'(expRef.pop_front()));
      if (runCnt == 0) firstRun = cyc;
      lastRun = cyc;
      runCnt++;
    end
    if (resValid && resReady) begin
      if (expRes.size() == 0) checkOutput("resUnexpected", 64'd1, 64'd0);
      else begin
        popped = expRes.pop_front();
        checkOutput("resScore", 64'(resScore), 64'(popped.score));
        checkOutput("resPosition", 64'(resPosition), 64'(popped.pos));
        checkOutput("resTimeout", 64'(resTimeout), 64'(popped.tmo));
      end
    end
  end

  task automatic clearCounts();
    loadCnt = 0;
    runCnt = 0;
  endtask

  // Pulses start with ref_len=len and checks the state the DUT moves to.
  task automatic startSearch(input logic [31:0] len);
    start = 1'b1;
    refLen = len;
    @(negedge clk);
    checkOutput("busyBeforeStart", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    refLen = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("busyAfterStart", 64'(busy), 64'd1);
    if (len == 32'd0) begin
      checkOutput("zeroLenResValid", 64'(resValid), 64'd1);
    end else begin
      checkOutput("sqgReadyAfterStart", 64'(sqgReady), 64'd1);
      checkOutput("dpRefLen", 64'(dpRefLen), 64'(len));
    end
    @(posedge clk); #1;
  endtask

  // Drives n beats into the squiggle (isRef=0) or reference (isRef=1) stream.
  task automatic applyStimulus(input bit isRef, input int n, input bit toggle, input logic [WL-1:0] seed);
    int idx = 0;
    int budget = 0;
    logic [WL-1:0] w;
    while (idx < n && budget < 400) begin
      w = seed + WL'(idx * 37);
      if (isRef) begin
        refValid = toggle ? (budget % 2 == 0) : 1'b1;
        refData = w;
      end else begin
        sqgValid = toggle ? (budget % 2 == 0) : 1'b1;
        sqgData = w;
      end
      @(negedge clk);
      if (isRef ? (refValid && refReady) : (sqgValid && sqgReady)) begin
        if (isRef) expRef.push_back(w);
        else expSqg.push_back(w);
        idx++;
      end
      @(posedge clk); #1;
      budget++;
    end
    refValid = 1'b0;
    sqgValid = 1'b0;
    checkOutput(isRef ? "refBeats" : "sqgBeats", 64'(idx), 64'(n));
  endtask

  task automatic finishResult(input logic [WL-1:0] score, input logic [31:0] pos);
    resExp_t e;
    e.score = score;
    e.pos = pos;
    e.tmo = 1'b0;
    expRes.push_back(e);
    dpBestScore = score;
    dpBestPos = pos;
    dpDone = 1'b1;
    @(posedge clk); #1;
    dpDone = 1'b0;
    dpBestScore = 16'hDEAD;
    dpBestPos = 32'h0BAD_0BAD;
    @(negedge clk);
    checkOutput("resValidAfterDone", 64'(resValid), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic releaseResult();
    resReady = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    resReady = 1'b0;
    checkOutput("resPending", 64'(expRes.size()), 64'd0);
  endtask

  task automatic fullSearch(input logic [31:0] len, input logic [WL-1:0] seed, input logic [WL-1:0] score, input logic [31:0] pos);
    clearCounts();
    startSearch(len);
    applyStimulus(1'b0, SL, 1'b0, seed);
    applyStimulus(1'b1, int'(len), 1'b0, seed + 16'h0800);
    finishResult(score, pos);
    releaseResult();
    checkOutput("fullLoadCount", 64'(loadCnt), 64'(SL));
    checkOutput("fullRunCount", 64'(runCnt), 64'(len));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("resetBusy", 64'(busy), 64'd0);
    checkOutput("resetResValid", 64'(resValid), 64'd0);
    checkOutput("resetScore", 64'(resScore), 64'd0);
    checkOutput("resetPosition", 64'(resPosition), 64'd0);
    checkOutput("resetRefLen", 64'(dpRefLen), 64'd0);
    @(posedge clk); #1;

    // Back-to-back streams, then a delayed done.
    clearCounts();
    startSearch(32'd25);
    applyStimulus(1'b0, SL, 1'b0, 16'h1000);
    applyStimulus(1'b1, 25, 1'b0, 16'h2000);
    repeat (3) begin
      @(negedge clk);
      checkOutput("drainNoResult", 64'(resValid), 64'd0);
      checkOutput("drainBusy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    finishResult(16'h0123, 32'd7);
    releaseResult();
    checkOutput("loadCount", 64'(loadCnt), 64'd5);
    checkOutput("loadSpan", 64'(lastLoad - firstLoad), 64'd4);
    checkOutput("runCount", 64'(runCnt), 64'd25);
    checkOutput("runSpan", 64'(lastRun - firstRun), 64'd24);
    checkOutput("loadToRunGap", 64'(firstRun - lastLoad), 64'd1);

    // Bubbly streams.
    clearCounts();
    startSearch(32'd25);
    applyStimulus(1'b0, SL, 1'b1, 16'h3000);
    applyStimulus(1'b1, 25, 1'b1, 16'h4000);
    finishResult(16'h00A5, 32'd24);
    releaseResult();
    checkOutput("bubbleLoadCount", 64'(loadCnt), 64'd5);
    checkOutput("bubbleRunCount", 64'(runCnt), 64'd25);
    checkOutput("bubbleRunSpan", 64'(lastRun - firstRun), 64'd48);

    // Zero-length search never touches the datapath.
    clearCounts();
    begin
      resExp_t e;
      e.score = 16'hFFFF;
      e.pos = 32'hFFFF_FFFF;
      e.tmo = 1'b0;
      expRes.push_back(e);
    end
    startSearch(32'd0);
    releaseResult();
    checkOutput("zeroLenLoads", 64'(loadCnt), 64'd0);
    checkOutput("zeroLenRuns", 64'(runCnt), 64'd0);

    // Result held by back-pressure; start and stray done are ignored.
    clearCounts();
    startSearch(32'd4);
    applyStimulus(1'b0, SL, 1'b0, 16'h5000);
    applyStimulus(1'b1, 4, 1'b0, 16'h6000);
    finishResult(16'h7777, 32'd3);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        start = 1'b1;
        refLen = 32'd3;
      end
      if (i == 6) begin
        dpDone = 1'b1;
        dpBestScore = 16'h5555;
        dpBestPos = 32'd99;
      end
      @(negedge clk);
      checkOutput("holdResValid", 64'(resValid), 64'd1);
      checkOutput("holdBusy", 64'(busy), 64'd1);
      checkOutput("holdScore", 64'(resScore), 64'h7777);
      checkOutput("holdPosition", 64'(resPosition), 64'd3);
      checkOutput("holdRefLen", 64'(dpRefLen), 64'd4);
      @(posedge clk); #1;
      start = 1'b0;
      dpDone = 1'b0;
    end
    releaseResult();
    fullSearch(32'd6, 16'h0700, 16'h0042, 32'd5);

    // Reset mid-stream discards the search.
    clearCounts();
    startSearch(32'd25);
    applyStimulus(1'b0, SL, 1'b0, 16'h8000);
    applyStimulus(1'b1, 12, 1'b0, 16'h9000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstRunCount", 64'(runCnt), 64'd12);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstRefReady", 64'(refReady), 64'd0);
    checkOutput("rstRunning", 64'(dpRunning), 64'd0);
    checkOutput("rstRefWord", 64'(dpRefWord), 64'd0);
    checkOutput("rstSqgWord", 64'(dpSqgWord), 64'd0);
    checkOutput("rstRefLen", 64'(dpRefLen), 64'd0);
    checkOutput("rstScore", 64'(resScore), 64'd0);
    checkOutput("rstPosition", 64'(resPosition), 64'd0);
    checkOutput("rstRefQueue", 64'(expRef.size()), 64'd0);
    @(posedge clk); #1;
    resReady = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("rstNoResult", 64'(resValid), 64'd0);
      @(posedge clk); #1;
    end
    resReady = 1'b0;
    fullSearch(32'd8, 16'h0A00, 16'h0BEE, 32'd2);

`ifdef DTW_CTRL_TIMEOUT_EN
    // Watchdog expiry with no done.
    begin
      resExp_t e;
      int waited;
      e.score = 16'hFFFF;
      e.pos = 32'hFFFF_FFFF;
      e.tmo = 1'b1;
      expRes.push_back(e);
      startSearch(32'd2);
      applyStimulus(1'b0, SL, 1'b0, 16'hC000);
      applyStimulus(1'b1, 2, 1'b0, 16'hD000);
      waited = 0;
      while (waited < 40) begin
        @(negedge clk);
        if (resValid) break;
        waited++;
        @(posedge clk); #1;
      end
      checkOutput("timeoutCycles", 64'(waited), 64'd16);
      checkOutput("timeoutFlag", 64'(resTimeout), 64'd1);
      @(posedge clk); #1;
      releaseResult();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
